// File: rtl/ps_mask_pkg.sv
// Shared constants for the red-pixel mask pipeline (window builder, kernel filter,
// later morphology stages).
package ps_mask_pkg;

   localparam int unsigned WIN_SIZE           = 3;
   localparam int unsigned CENTER_IDX         = 1;
   localparam int unsigned ROW_W              = 2;
   localparam logic [ROW_W-1:0] ROW_FULL      = 2'd2;
   localparam int unsigned DEFAULT_LINE_WIDTH = 640;
   localparam int unsigned DEFAULT_COL_W      = 10;

endpackage

// File: rtl/ps_binary_line_ram.sv
// Single-port 1-bit line memory: combinational read of the addressed entry
// (pre-write contents), synchronous write on the same address.
module ps_binary_line_ram #(
   parameter int unsigned DEPTH  = 640,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wdata,
   output logic              rdata
);

   logic mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ps_binary_window3x3.sv
// Streaming 3x3 window over the 1-bit red mask; two line RAMs hold the previous
// lines and o_valid is suppressed for windows reaching off the top/left edge.
module ps_binary_window3x3
   import ps_mask_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH,
   parameter int unsigned COL_W      = DEFAULT_COL_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_pixel,
   input  logic                i_valid,
   input  logic                i_sof,
   input  logic                i_eol,
   output logic [WIN_SIZE-1:0] o_r0_data,
   output logic [WIN_SIZE-1:0] o_r1_data,
   output logic [WIN_SIZE-1:0] o_r2_data,
   output logic                o_valid,
   output logic                o_overrun
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN_SIZE - 1);

   logic [COL_W-1:0] col;
   logic [COL_W-1:0] col_eff;
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] row_eff;
   logic             a_rd;
   logic             b_rd;

   // SOF forces this pixel to (0,0) regardless of the running counters
   assign col_eff = i_sof ? '0 : col;
   assign row_eff = i_sof ? '0 : row;

   ps_binary_line_ram #(
      .DEPTH  (LINE_WIDTH),
      .ADDR_W (COL_W)
   ) u_ram_a (
      .clk   (i_clk),
      .we    (i_valid),
      .addr  (col_eff),
      .wdata (i_pixel),
      .rdata (a_rd)
   );

   ps_binary_line_ram #(
      .DEPTH  (LINE_WIDTH),
      .ADDR_W (COL_W)
   ) u_ram_b (
      .clk   (i_clk),
      .we    (i_valid),
      .addr  (col_eff),
      .wdata (a_rd),
      .rdata (b_rd)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col       <= '0;
         row       <= '0;
         o_r0_data <= '0;
         o_r1_data <= '0;
         o_r2_data <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_valid) begin
            o_r2_data <= {i_pixel, o_r2_data[WIN_SIZE-1:1]};
            o_r1_data <= {a_rd,    o_r1_data[WIN_SIZE-1:1]};
            o_r0_data <= {b_rd,    o_r0_data[WIN_SIZE-1:1]};
            o_valid   <= (row_eff == ROW_FULL) && (col_eff >= COL_MIN);
            if (i_sof) o_overrun <= 1'b0;
            if (i_eol) begin
               col <= '0;
               row <= (row_eff == ROW_FULL) ? ROW_FULL : row_eff + ROW_W'(1);
            end else if (col_eff == COL_LAST) begin
               // over-long line: hold on the last entry until EOL arrives
               col       <= COL_LAST;
               row       <= row_eff;
               o_overrun <= 1'b1;
            end else begin
               col <= col_eff + COL_W'(1);
               row <= row_eff;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps_binary_window3x3.sv
// Directed bench for ps_binary_window3x3 with an 8-pixel line.
module tb_ps_binary_window3x3;

   localparam int unsigned LW = 8;
   localparam int unsigned CW = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       pixel;
   logic       valid;
   logic       sof;
   logic       eol;
   logic [2:0] r0_data;
   logic [2:0] r1_data;
   logic [2:0] r2_data;
   logic       win_valid;
   logic       overrun;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned pulses;

   ps_binary_window3x3 #(
      .LINE_WIDTH (LW),
      .COL_W      (CW)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_pixel   (pixel),
      .i_valid   (valid),
      .i_sof     (sof),
      .i_eol     (eol),
      .o_r0_data (r0_data),
      .o_r1_data (r1_data),
      .o_r2_data (r2_data),
      .o_valid   (win_valid),
      .o_overrun (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One accepted pixel; optionally preceded by a random idle cycle.
   task automatic send(input logic p, input logic s, input logic e, input bit gaps);
      if (gaps && $urandom_range(0, 9) < 3) begin
         valid = 1'b0;
         @(posedge clk);
         #1;
         check_val("gap_valid", win_valid, 0);
      end
      pixel = p;
      sof   = s;
      eol   = e;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      sof   = 1'b0;
      eol   = 1'b0;
   endtask

   // Three all-ones lines, the last one cut after stop_col.
   task automatic ones_frame(input bit gaps, input int unsigned stop_col, output int unsigned n_pulse);
      n_pulse = 0;
      for (int unsigned ln = 0; ln < 3; ln++) begin
         for (int unsigned c = 0; c < LW; c++) begin
            logic exp_v;
            if (ln == 2 && c > stop_col) break;
            send(1'b1, (ln == 0 && c == 0), (c == LW - 1), gaps);
            exp_v = (ln == 2 && c >= 2);
            check_val("ones_valid", win_valid, exp_v);
            if (exp_v) begin
               n_pulse++;
               check_val("ones_r0", r0_data, 3'b111);
               check_val("ones_r1", r1_data, 3'b111);
               check_val("ones_r2", r2_data, 3'b111);
            end
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      pixel = 1'b0;
      valid = 1'b0;
      sof   = 1'b0;
      eol   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_r0", r0_data, 0);
      check_val("rst_r1", r1_data, 0);
      check_val("rst_r2", r2_data, 0);
      check_val("rst_valid", win_valid, 0);
      check_val("rst_overrun", overrun, 0);
      rst = 1'b0;

      // all-ones frame
      ones_frame(1'b0, LW - 1, pulses);
      check_val("t1_pulses", pulses, 6);

      // single set pixel at (1,3)
      for (int unsigned ln = 0; ln < 3; ln++) begin
         for (int unsigned c = 0; c < LW; c++) begin
            logic [2:0] exp_r1;
            send((ln == 1 && c == 3), (ln == 0 && c == 0), (c == LW - 1), 1'b0);
            if (ln == 2 && c >= 2) begin
               case (c)
                  3:       exp_r1 = 3'b100;
                  4:       exp_r1 = 3'b010;
                  5:       exp_r1 = 3'b001;
                  default: exp_r1 = 3'b000;
               endcase
               check_val("dot_valid", win_valid, 1);
               check_val("dot_r0", r0_data, 0);
               check_val("dot_r1", r1_data, exp_r1);
               check_val("dot_r2", r2_data, 0);
            end else begin
               check_val("dot_valid_off", win_valid, 0);
            end
         end
      end

      // over-long line: 10 pixels, EOL on the 10th
      for (int unsigned k = 0; k < 10; k++) begin
         send(1'b0, (k == 0), (k == 9), 1'b0);
         check_val("ovr_flag", overrun, (k >= 7));
         check_val("ovr_valid", win_valid, 0);
      end
      for (int unsigned c = 0; c < LW; c++) send(1'b0, 1'b0, (c == LW - 1), 1'b0);
      check_val("ovr_sticky", overrun, 1);
      send(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("ovr_sof_clear", overrun, 0);

      // all-ones frame with random idle gaps
      ones_frame(1'b1, LW - 1, pulses);
      check_val("t4_pulses", pulses, 6);

      // reset in the middle of line 2
      ones_frame(1'b0, 3, pulses);
      check_val("t5_pre_pulses", pulses, 2);
      rst   = 1'b1;
      valid = 1'b1;
      pixel = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      valid = 1'b0;
      check_val("mid_rst_r0", r0_data, 0);
      check_val("mid_rst_r1", r1_data, 0);
      check_val("mid_rst_r2", r2_data, 0);
      check_val("mid_rst_valid", win_valid, 0);
      check_val("mid_rst_overrun", overrun, 0);
      ones_frame(1'b0, LW - 1, pulses);
      check_val("t5_post_pulses", pulses, 6);

      // SOF and EOL on the same pixel counts as a full line
      send(1'b1, 1'b1, 1'b1, 1'b0);
      check_val("soe_valid", win_valid, 0);
      for (int unsigned ln = 1; ln < 3; ln++) begin
         for (int unsigned c = 0; c < LW; c++) begin
            logic exp_v;
            send(1'b1, 1'b0, (c == LW - 1), 1'b0);
            exp_v = (ln == 2 && c >= 2);
            check_val("soe_line_valid", win_valid, exp_v);
            if (exp_v) check_val("soe_r2", r2_data, 3'b111);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps_binary_window3x3.md
Name: ps_binary_window3x3

Overview:
- Builds a streaming 3x3 window over the 1-bit red-pixel mask stream.
- Feeds the 3x3 red-pixel kernel filter directly downstream with three 3-bit row slices plus a valid flag.
- Stores the two previous mask lines in on-chip line RAM and shifts three columns per row.
- Suppresses windows that would read off the top or left edge of the frame.

Parameters:
- LINE_WIDTH, 640: active pixels per line; sets line RAM depth.
- COL_W, 10: column counter width; must satisfy 2^COL_W >= LINE_WIDTH.

Ports:
- i_clk  input  1  single system clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_pixel  input  1  mask bit of the incoming pixel (1 = red).
- i_valid  input  1  i_pixel, i_sof and i_eol are qualified this cycle.
- i_sof  input  1  with i_valid: this pixel is row 0, column 0 of a new frame.
- i_eol  input  1  with i_valid: this pixel is the last of its line.
- o_r0_data  output  3  top row of window (oldest line); [0]=left, [2]=right (newest column).
- o_r1_data  output  3  middle row; bit [1] is the window centre.
- o_r2_data  output  3  bottom row (current line).
- o_valid  output  1  window is complete and inside the frame.
- o_overrun  output  1  sticky: a line exceeded LINE_WIDTH pixels since reset or the last SOF.

Behaviour:
- Reset values: all outputs 0; col, row, and the window shift registers 0. Line RAM contents are not cleared; the row gating below masks stale data.
- Accepted pixel: any cycle with i_valid=1. Cycles with i_valid=0 change no state and drive o_valid=0.
- SOF handling: if i_sof=1, the pixel is processed as col=0 and row=0, overriding the counters. SOF also clears o_overrun.
- Line RAM access: two 1-bit x LINE_WIDTH RAMs, A (previous line) and B (line before that). For an accepted pixel at column c, read A[c] and B[c] read-first, then write B[c]<=A[c] and A[c]<=i_pixel in the same cycle.
- Window shift on each accepted pixel:
  - r2 <= {i_pixel, r2[2:1]}
  - r1 <= {A[c], r1[2:1]}
  - r0 <= {B[c], r0[2:1]}
  - New data enters bit [2]; bit [0] is the oldest column.
- Output registration and latency: o_r*_data are the shift registers themselves. Latency is 1 cycle from the accepted pixel to the updated window.
- o_valid: registered. Set to 1 on the cycle after an accepted pixel with row>=2 and col>=2, using that pixel's row/col; 0 otherwise. The window centre is at frame position (row-1, col-1).
- Counters after an accepted pixel:
  - i_eol=1: col<=0; row<=row+1, saturating at 2. Row needs only 2 bits.
  - i_eol=0: col<=col+1.
- Overrun: an accepted pixel arriving at col=LINE_WIDTH-1 without i_eol sets o_overrun=1. Col holds at LINE_WIDTH-1; later pixels in that line overwrite the last RAM entry and still shift the window. The next i_eol recovers normally.
- Simultaneous i_sof and i_eol: process the pixel as col=0, row=0, then apply the EOL update (col<=0, row<=1).
- Short lines (EOL before LINE_WIDTH): legal. RAM entries beyond the short length go stale and are never read into a valid window of an equal-length frame.
- Reset mid-line or mid-frame:
  - Outputs drop to 0 the next cycle.
  - Row=0 guarantees no o_valid until two full new lines have been received.
- Throughput: 1 pixel per clock, no backpressure; the downstream filter must accept every o_valid.

Decomposition:
- Shared package ps_mask_pkg holds:
  - WIN_SIZE=3, CENTER_IDX=1
  - the ROW_W=2 constant
  - the row saturation value ROW_FULL=2
  - the default LINE_WIDTH/COL_W pair, for reuse by the filter and future morphology stages.
- One sub-module: ps_binary_line_ram, a single-port read-first 1-bit x LINE_WIDTH memory with synchronous write. It is instantiated twice (A, B); the read data used for the shift is the pre-write contents.

Test Plan:
- LINE_WIDTH=8, 3 lines of all-ones, SOF on the first pixel, EOL on pixel 7 of each line -> o_valid=0 through the end of line 1; on line 2, o_valid=1 for cols 2..7 (6 pulses), each with o_r0/r1/r2_data=3'b111.
- Single 1 at frame (row 1, col 3), all others 0, 3 lines of 8 -> at the line-2 col-4 window o_r1_data=3'b010 and o_r0/o_r2_data=0; the col-3 window shows r1=3'b100 and the col-5 window shows r1=3'b001.
- Line 0 driven with 9 pixels, no EOL until the 10th -> o_overrun=1 after the 8th pixel (col 7); stays 1 until the next SOF, which clears it.
- Insert random i_valid=0 gaps (~30%) into the first test -> identical o_r*_data sequence on o_valid cycles; o_valid never 1 on the cycle after a gap.
- Assert i_rst for 1 cycle mid line 2 -> the next cycle all outputs are 0; after a new SOF, no o_valid until line 2 col 2 of the new frame.
- i_sof and i_eol together on one pixel, then 2 full lines -> o_valid first asserts at col 2 of the second full line (row count reached 2 after the combined pixel counted as one line).
